// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned IMEM_DEPTH = 256;
   localparam int unsigned CNT_W      = 9;

   localparam logic [DATA_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } imem_wr_t;

   // LEN byte of zero encodes a full 256-byte program.
   function automatic logic [CNT_W-1:0] frame_len(input logic [DATA_W-1:0] len_byte);
      return (len_byte == '0) ? CNT_W'(IMEM_DEPTH) : CNT_W'(len_byte);
   endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// Running 8-bit frame checksum; zero_c_o tells whether adding data_i would close the sum to zero.
module imem_loader_csum
   import imem_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clr_i,
   input  logic              add_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              zero_c_o
);

   logic [DATA_W-1:0] sum_q;
   logic [DATA_W-1:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (add_i) begin
         sum_d = DATA_W'(sum_q + data_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign zero_c_o = (DATA_W'(sum_q + data_i) == '0);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader into the 256x8 instruction memory; holds the CPU while loading.
// Optional checksum byte after the data is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [DATA_W-1:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
   parameter logic [ADDR_W-1:0] START_ADDR = 8'h00
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [DATA_W-1:0] imem_wdata_o,
   output logic              cpu_hold_o,
   output logic              load_done_o,
   output logic              load_err_o
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   imem_wr_t          wr_q, wr_d;
   logic              ready_q, ready_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              rx_accept;

   assign rx_accept = rx_valid_i && ready_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic csum_clr, csum_add, csum_zero;

   imem_loader_csum u_csum (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_i    (csum_clr),
      .add_i    (csum_add),
      .data_i   (rx_data_i),
      .zero_c_o (csum_zero)
   );
`endif

   // Next-state and registered-output decode; outputs follow the state being entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wr_d.we = 1'b0;
      err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_clr = 1'b0;
      csum_add = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (rx_accept && (rx_data_i == SYNC_BYTE)) begin
               state_d = ST_LEN;
               err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_clr = 1'b1;
`endif
            end
         end
         ST_LEN: begin
            if (rx_accept) begin
               cnt_d   = frame_len(rx_data_i);
               addr_d  = START_ADDR;
               state_d = ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_add = 1'b1;
`endif
            end
         end
         ST_DATA: begin
            if (rx_accept) begin
               wr_d.we   = 1'b1;
               wr_d.addr = addr_q;
               wr_d.data = rx_data_i;
               addr_d    = ADDR_W'(addr_q + ADDR_W'(1));
               cnt_d     = CNT_W'(cnt_q - CNT_W'(1));
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_add = 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = ST_CSUM;
`else
               if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (rx_accept) begin
               if (csum_zero) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d != ST_DONE);
      hold_d  = (state_d == ST_LEN) || (state_d == ST_DATA) ||
                (state_d == ST_CSUM) || (state_d == ST_ERR);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= '0;
         ready_q <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         ready_q <= ready_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign rx_ready_o   = ready_q;
   assign imem_we_o    = wr_q.we;
   assign imem_addr_o  = wr_q.addr;
   assign imem_wdata_o = wr_q.data;
   assign cpu_hold_o   = hold_q;
   assign load_done_o  = done_q;
   assign load_err_o   = err_q;

endmodule
